vga_picture_bouncer: RTL and testbench
======================================

# vga_picture_bouncer

Pixel-source stage feeding `vga_data` of the VGA driver in the 25 MHz pixel domain. For each `vga_xpos`/`vga_ypos` it emits the colour of a PIC_W×PIC_H picture stored in an external synchronous ROM, or BG_COLOR outside the picture window. The window position moves diagonally by STEP pixels once per frame and reverses direction at the screen edges (bounce). This block replaces the static pattern generator on the data path between position counters and RGB output.

## Interface
- H_DISP, 640, active pixels per line
- V_DISP, 480, active lines per frame
- PIC_W, 100, picture width in pixels
- PIC_H, 100, picture height in lines
- AW, 14, ROM address width; must satisfy 2^AW >= PIC_W*PIC_H
- BG_COLOR, 24'h000000, colour outside the window
- STEP, 1, pixels moved per frame on each axis
- clk_25m  in  1  pixel clock; the only clock
- rst  in  1  synchronous, active-high reset
- vga_xpos  in  12  current pixel column from driver
- vga_ypos  in  12  current pixel row from driver
- move_en  in  1  1 = update position at frame end
- rom_addr  out  AW  picture ROM read address (registered)
- rom_q  in  24  ROM data, valid one cycle after rom_addr
- vga_data  out  24  {R,G,B} pixel to driver (registered)
- frame_tick  out  1  one-cycle pulse at end of active frame

## Operation
- Position state: pic_x, pic_y (12 b), dir_x, dir_y (1 = increasing). Reset: 0, 0, 1, 1.
- Stage 0 (combinational on inputs): hit = (vga_xpos >= pic_x) && (vga_xpos < pic_x+PIC_W) && (vga_ypos >= pic_y) && (vga_ypos < pic_y+PIC_H); all compares unsigned, 12 b, no wrap.
- Stage 1 (register): if hit, rom_addr <= (vga_ypos-pic_y)*PIC_W + (vga_xpos-pic_x), truncated to AW; else rom_addr holds. hit_d1 <= hit.
- Stage 2: hit_d2 <= hit_d1 (aligns with rom_q).
- Stage 3 (register): vga_data <= hit_d2 ? rom_q : BG_COLOR.
- Frame end: eof = (vga_xpos == H_DISP-1) && (vga_ypos == V_DISP-1). frame_tick <= eof && !eof_d1 (rising edge only; held inputs give one pulse).
- Position update on the cycle frame_tick is registered high, only if move_en = 1; per axis (X shown, Y identical with pic_y, PIC_H, V_DISP):
  - dir_x=1: if pic_x+STEP >= H_DISP-PIC_W then pic_x <= H_DISP-PIC_W, dir_x <= 0; else pic_x <= pic_x+STEP.
  - dir_x=0: if pic_x <= STEP then pic_x <= 0, dir_x <= 1; else pic_x <= pic_x-STEP.
- X and Y update independently in the same cycle; corner hit flips both.
- Position never changes mid-frame → no tearing; in-flight pipeline pixels keep the hit/address already computed.
- move_en = 0: frame_tick still pulses; position and direction hold.

## Timing
- Reset values: rom_addr = 0, vga_data = 24'h000000, frame_tick = 0, hit_d1/hit_d2/eof_d1 = 0, pic_x = pic_y = 0, dir_x = dir_y = 1.
- Latency: inputs at cycle t → rom_addr at t+1 → rom_q at t+2 → vga_data at t+3. Driver must present positions 3 cycles ahead.
- frame_tick high exactly one cycle, at t+1 after eof first seen at t; new position effective for compares from t+2.
- rst mid-frame: all state returns to reset values at next edge; pipeline flushed (vga_data = 0 until refilled, first valid pixel 3 cycles after rst deasserts).
- Throughput: one pixel per clock, no stalls.

## Test plan
- Reset: rst high 3 cycles with random inputs → vga_data = 0, rom_addr = 0, frame_tick = 0 throughout and 1 cycle after release.
- Window hit: after reset drive (x=5, y=2) at t → rom_addr = 205 at t+1; rom_q = 24'hABCDEF at t+2 → vga_data = 24'hABCDEF at t+3.
- Window miss: drive (x=100, y=0) → rom_addr holds previous value, vga_data = BG_COLOR at t+3 even if rom_q = 24'hFFFFFF.
- Frame tick: hold (639, 479) for 4 cycles → exactly one frame_tick pulse; pic moves (0,0) → (1,1); a pixel at (0,0) is then a miss, (1,1) a hit with rom_addr = 0.
- Bounce: 380 frames with move_en=1 → pic_y = 380, dir_y = 0; frame 381 → pic_y = 379, pic_x = 381; frame 540 → pic_x = 540, dir_x = 0; frame 541 → pic_x = 539.
- move_en = 0 for 10 frames → 10 frame_tick pulses, pic_x/pic_y unchanged; assert rst mid-frame → pic returns to (0,0), vga_data = 0 next cycle.

Source files
------------

// File: rtl/vga_picture_bouncer.sv
// Purpose: picture-window pixel source whose window bounces diagonally once per frame.
// Latency: position in at t -> rom_addr at t+1 -> vga_data at t+3.
// Backpressure: none; accepts one pixel position every clock, never stalls.
module vga_picture_bouncer #(
    parameter int          H_DISP   = 640,
    parameter int          V_DISP   = 480,
    parameter int          PIC_W    = 100,
    parameter int          PIC_H    = 100,
    parameter int          AW       = 14,
    parameter logic [23:0] BG_COLOR = 24'h000000,
    parameter int          STEP     = 1
) (
    input  logic          clk_25m,
    input  logic          rst,
    input  logic [11:0]   vga_xpos,
    input  logic [11:0]   vga_ypos,
    input  logic          move_en,
    output logic [AW-1:0] rom_addr,
    input  logic [23:0]   rom_q,
    output logic [23:0]   vga_data,
    output logic          frame_tick
);

    localparam logic [11:0] X_MAX = 12'(H_DISP - PIC_W);
    localparam logic [11:0] Y_MAX = 12'(V_DISP - PIC_H);

    logic [11:0] pic_x, pic_y;
    logic        dir_x, dir_y;
    logic        hit_d1, hit_d2, eof_d1;

    logic        hit, eof;
    logic [12:0] x_end, y_end;
    logic [11:0] rel_x, rel_y;
    logic [23:0] addr_full;
    logic [11:0] pic_x_nxt, pic_y_nxt;
    logic        dir_x_nxt, dir_y_nxt;

    // One axis of the bounce: returns {new_dir, new_pos}; the edge clamps and flips.
    function automatic logic [12:0] bounce(input logic [11:0] pos, input logic dir,
                                           input logic [11:0] max_pos);
        logic [12:0] res;
        if (dir) begin
            if (({1'b0, pos} + 13'(STEP)) >= {1'b0, max_pos})
                res = {1'b0, max_pos};
            else
                res = {1'b1, pos + 12'(STEP)};
        end else begin
            if (pos <= 12'(STEP))
                res = {1'b1, 12'd0};
            else
                res = {1'b0, pos - 12'(STEP)};
        end
        return res;
    endfunction

    always_comb begin
        x_end     = {1'b0, pic_x} + 13'(PIC_W);
        y_end     = {1'b0, pic_y} + 13'(PIC_H);
        hit       = (vga_xpos >= pic_x) && ({1'b0, vga_xpos} < x_end) &&
                    (vga_ypos >= pic_y) && ({1'b0, vga_ypos} < y_end);
        rel_x     = vga_xpos - pic_x;
        rel_y     = vga_ypos - pic_y;
        addr_full = 24'(rel_y) * 24'(PIC_W) + 24'(rel_x);
        eof       = (vga_xpos == 12'(H_DISP - 1)) && (vga_ypos == 12'(V_DISP - 1));
    end

    // Position only moves on the tick cycle, so a frame never sees two windows.
    always_comb begin
        pic_x_nxt = pic_x;
        pic_y_nxt = pic_y;
        dir_x_nxt = dir_x;
        dir_y_nxt = dir_y;
        if (frame_tick && move_en) begin
            {dir_x_nxt, pic_x_nxt} = bounce(pic_x, dir_x, X_MAX);
            {dir_y_nxt, pic_y_nxt} = bounce(pic_y, dir_y, Y_MAX);
        end
    end

    always_ff @(posedge clk_25m) begin
        if (rst) begin
            pic_x      <= 12'd0;
            pic_y      <= 12'd0;
            dir_x      <= 1'b1;
            dir_y      <= 1'b1;
            rom_addr   <= '0;
            hit_d1     <= 1'b0;
            hit_d2     <= 1'b0;
            vga_data   <= 24'h000000;
            eof_d1     <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            pic_x      <= pic_x_nxt;
            pic_y      <= pic_y_nxt;
            dir_x      <= dir_x_nxt;
            dir_y      <= dir_y_nxt;
            if (hit)
                rom_addr <= addr_full[AW-1:0];
            hit_d1     <= hit;
            hit_d2     <= hit_d1;
            vga_data   <= hit_d2 ? rom_q : BG_COLOR;
            eof_d1     <= eof;
            frame_tick <= eof && !eof_d1;
        end
    end

endmodule

// File: tb/tb_vga_picture_bouncer.sv
// Directed bench for vga_picture_bouncer: pixel pipeline vectors plus frame/bounce/reset sequences.
module tb_vga_picture_bouncer;

    logic        clk_25m = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] vga_xpos = 12'd0;
    logic [11:0] vga_ypos = 12'd0;
    logic        move_en = 1'b0;
    logic [13:0] rom_addr;
    logic [23:0] rom_q = 24'h0;
    logic [23:0] vga_data;
    logic        frame_tick;

    int tests = 0;
    int failed = 0;
    int tick_cnt = 0;

    vga_picture_bouncer dut (
        .clk_25m   (clk_25m),
        .rst       (rst),
        .vga_xpos  (vga_xpos),
        .vga_ypos  (vga_ypos),
        .move_en   (move_en),
        .rom_addr  (rom_addr),
        .rom_q     (rom_q),
        .vga_data  (vga_data),
        .frame_tick(frame_tick)
    );

    always #20 clk_25m = ~clk_25m;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic [23:0] q;
        logic [13:0] exp_addr;
        logic [23:0] exp_data;
        logic        exp_tick;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the edge, then sample at the falling edge.
    task automatic apply(input logic r, input logic [11:0] x, input logic [11:0] y,
                         input logic me, input logic [23:0] q);
        @(posedge clk_25m);
        #1;
        rst = r;
        vga_xpos = x;
        vga_ypos = y;
        move_en = me;
        rom_q = q;
        @(negedge clk_25m);
        tick_cnt += int'(frame_tick);
    endtask

    task automatic do_frame(input logic me);
        apply(1'b0, 12'd639, 12'd479, me, 24'h0);
        apply(1'b0, 12'd600, 12'd400, me, 24'h0);
    endtask

    initial begin
        // rom_q in row k is the ROM word for the address presented in row k-2.
        vecs[0]  = '{12'd5,   12'd2,   24'h000000, 14'd0,    24'h000000, 1'b0};
        vecs[1]  = '{12'd100, 12'd0,   24'h000000, 14'd205,  24'h000000, 1'b0};
        vecs[2]  = '{12'd99,  12'd99,  24'hABCDEF, 14'd205,  24'h000000, 1'b0};
        vecs[3]  = '{12'd100, 12'd99,  24'hFFFFFF, 14'd9999, 24'hABCDEF, 1'b0};
        vecs[4]  = '{12'd0,   12'd100, 24'h123456, 14'd9999, 24'h000000, 1'b0};
        vecs[5]  = '{12'd50,  12'd50,  24'hFFFFFF, 14'd9999, 24'h123456, 1'b0};
        vecs[6]  = '{12'd0,   12'd0,   24'hFFFFFF, 14'd5050, 24'h000000, 1'b0};
        vecs[7]  = '{12'd600, 12'd0,   24'h00FF00, 14'd0,    24'h000000, 1'b0};
        vecs[8]  = '{12'd600, 12'd0,   24'h0000FF, 14'd0,    24'h00FF00, 1'b0};
        vecs[9]  = '{12'd600, 12'd0,   24'hFFFFFF, 14'd0,    24'h0000FF, 1'b0};
        vecs[10] = '{12'd600, 12'd0,   24'h000000, 14'd0,    24'h000000, 1'b0};

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
                  1'($urandom_range(0, 1)), 24'($urandom));
            check("rst_vga_data", 32'(vga_data), 32'h0);
            check("rst_rom_addr", 32'(rom_addr), 32'h0);
            check("rst_tick", 32'(frame_tick), 32'h0);
        end
        apply(1'b0, 12'd600, 12'd400, 1'b0, 24'h0);
        check("rst_rel_vga_data", 32'(vga_data), 32'h0);
        check("rst_rel_rom_addr", 32'(rom_addr), 32'h0);
        check("rst_rel_tick", 32'(frame_tick), 32'h0);

        // Pixel pipeline vectors
        for (int i = 0; i < 11; i++) begin
            apply(1'b0, vecs[i].x, vecs[i].y, 1'b0, vecs[i].q);
            check($sformatf("vec%0d_rom_addr", i), 32'(rom_addr), 32'(vecs[i].exp_addr));
            check($sformatf("vec%0d_vga_data", i), 32'(vga_data), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_tick", i), 32'(frame_tick), 32'(vecs[i].exp_tick));
        end

        // Held end-of-frame position yields a single tick and one step
        tick_cnt = 0;
        for (int i = 0; i < 4; i++) apply(1'b0, 12'd639, 12'd479, 1'b1, 24'h0);
        apply(1'b0, 12'd600, 12'd400, 1'b1, 24'h0);
        apply(1'b0, 12'd600, 12'd400, 1'b1, 24'h0);
        check("hold_tick_count", 32'(tick_cnt), 32'd1);
        check("step_pic_x", 32'(dut.pic_x), 32'd1);
        check("step_pic_y", 32'(dut.pic_y), 32'd1);
        apply(1'b0, 12'd50, 12'd50, 1'b0, 24'h0);
        apply(1'b0, 12'd0, 12'd0, 1'b0, 24'h0);
        check("step_addr_50_50", 32'(rom_addr), 32'd4949);
        apply(1'b0, 12'd1, 12'd1, 1'b0, 24'h0);
        check("step_miss_0_0_holds", 32'(rom_addr), 32'd4949);
        apply(1'b0, 12'd600, 12'd400, 1'b0, 24'h0);
        check("step_hit_1_1_addr", 32'(rom_addr), 32'd0);

        // Bounce: one frame already done, run to 380
        for (int i = 0; i < 379; i++) do_frame(1'b1);
        apply(1'b0, 12'd600, 12'd400, 1'b0, 24'h0);
        check("f380_pic_y", 32'(dut.pic_y), 32'd380);
        check("f380_dir_y", 32'(dut.dir_y), 32'd0);
        check("f380_pic_x", 32'(dut.pic_x), 32'd380);
        do_frame(1'b1);
        apply(1'b0, 12'd600, 12'd400, 1'b0, 24'h0);
        check("f381_pic_y", 32'(dut.pic_y), 32'd379);
        check("f381_pic_x", 32'(dut.pic_x), 32'd381);
        for (int i = 0; i < 159; i++) do_frame(1'b1);
        apply(1'b0, 12'd600, 12'd400, 1'b0, 24'h0);
        check("f540_pic_x", 32'(dut.pic_x), 32'd540);
        check("f540_dir_x", 32'(dut.dir_x), 32'd0);
        do_frame(1'b1);
        apply(1'b0, 12'd600, 12'd400, 1'b0, 24'h0);
        check("f541_pic_x", 32'(dut.pic_x), 32'd539);
        check("f541_pic_y", 32'(dut.pic_y), 32'd219);

        // move_en low: ticks continue, position frozen
        tick_cnt = 0;
        for (int i = 0; i < 10; i++) do_frame(1'b0);
        apply(1'b0, 12'd600, 12'd400, 1'b0, 24'h0);
        check("hold_tick_count10", 32'(tick_cnt), 32'd10);
        check("hold_pic_x", 32'(dut.pic_x), 32'd539);
        check("hold_pic_y", 32'(dut.pic_y), 32'd219);

        // Mid-frame reset with a full pipeline
        for (int i = 0; i < 4; i++) apply(1'b0, 12'd560, 12'd250, 1'b0, 24'hAAAAAA);
        check("pre_rst_vga_data", 32'(vga_data), 32'hAAAAAA);
        apply(1'b1, 12'd560, 12'd250, 1'b0, 24'hAAAAAA);
        apply(1'b0, 12'd7, 12'd3, 1'b0, 24'h5A5A5A);
        check("mid_rst_vga_data", 32'(vga_data), 32'h0);
        check("mid_rst_rom_addr", 32'(rom_addr), 32'h0);
        check("mid_rst_pic_x", 32'(dut.pic_x), 32'd0);
        check("mid_rst_pic_y", 32'(dut.pic_y), 32'd0);
        check("mid_rst_dirs", 32'({dut.dir_x, dut.dir_y}), 32'd3);
        apply(1'b0, 12'd600, 12'd400, 1'b0, 24'h5A5A5A);
        check("refill1_rom_addr", 32'(rom_addr), 32'd307);
        check("refill1_vga_data", 32'(vga_data), 32'h0);
        apply(1'b0, 12'd600, 12'd400, 1'b0, 24'h5A5A5A);
        check("refill2_vga_data", 32'(vga_data), 32'h0);
        apply(1'b0, 12'd600, 12'd400, 1'b0, 24'h000000);
        check("refill3_vga_data", 32'(vga_data), 32'h5A5A5A);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
